ex_stage: RTL and testbench

- Execute stage sitting directly downstream of the ID/EX pipeline register.
- Consumes the decoded ALU control, operands A/B, destination register and RegWrite flag.
- Produces a registered result toward EX/MEM.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers; drives a stall back to the ID/EX enable when a dependent HI/LO instruction arrives while the unit is busy.

---
 rtl/ex_stage_if.sv | 34 +++
 rtl/ex_stage.sv | 193 +++++++++++++++++++
 tb/tb_ex_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX -> EX/MEM bus bundle for the execute stage.
//   master : upstream ID/EX side, drives the decoded instruction, sees results/stall
//   slave  : ex_stage side, consumes the instruction, drives results/stall/busy
//   inputs : iValid, iALUCtrl[3:0], iA/iB[WIDTH], iRegDest[4:0], iRegWrite
//   outputs: oResult[WIDTH], oZero, oRegDest[4:0], oRegWrite, oValid,
//            oStall (combinational), oBusy, oOverflow
interface ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             iValid;
  logic [3:0]       iALUCtrl;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [4:0]       iRegDest;
  logic             iRegWrite;
  logic [WIDTH-1:0] oResult;
  logic             oZero;
  logic [4:0]       oRegDest;
  logic             oRegWrite;
  logic             oValid;
  logic             oStall;
  logic             oBusy;
  logic             oOverflow;

  modport master (
    output iValid, iALUCtrl, iA, iB, iRegDest, iRegWrite,
    input  oResult, oZero, oRegDest, oRegWrite, oValid, oStall, oBusy, oOverflow
  );

  modport slave (
    input  iValid, iALUCtrl, iA, iB, iRegDest, iRegWrite,
    output oResult, oZero, oRegDest, oRegWrite, oValid, oStall, oBusy, oOverflow
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU and an iterative (WIDTH-step)
// multiply/divide unit owning the HI/LO registers.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : ex_stage_if.slave (instruction in, registered result out,
//             combinational oStall back to the ID/EX enable, oBusy)
// Optional: define EX_OVF_TRAP_EN to flag signed overflow on ADD/SUB and
// suppress the register write for that result.
module ex_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  ex_stage_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADDU  = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;       // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   r_m;       // mul: |A| addend; div: |B| divisor
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_q;   // operand signs differ (product/quotient sign)
  logic               r_neg_r;   // dividend negative (remainder sign)
  logic               r_div0;

  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic [4:0]         r_rd;
  logic               r_rw;
  logic               r_valid;
  logic               r_ovf;

  logic               w_busy, w_stall, w_accept, w_is_md, w_is_mf, w_signed;
  logic               w_a_neg, w_b_neg, w_legal, w_ovf;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_sum, w_diff, w_alu;
  logic [WIDTH:0]     w_shift, w_trial, w_addsum;
  logic [2*WIDTH-1:0] w_step, w_prod_neg;
  logic [WIDTH-1:0]   w_quo, w_rem;

  assign w_is_md  = (bus.iALUCtrl[3:2] == 2'b10);
  assign w_is_mf  = (bus.iALUCtrl == OP_MFHI) || (bus.iALUCtrl == OP_MFLO);
  assign w_signed = ~bus.iALUCtrl[0];
  assign w_busy   = (r_state != S_IDLE);
  assign w_stall  = bus.iValid & w_busy & (w_is_md | w_is_mf);
  assign w_accept = bus.iValid & ~w_stall;

  // Magnitudes for the iterative unit; unsigned ops never see a sign
  assign w_a_neg = w_signed & bus.iA[WIDTH-1];
  assign w_b_neg = w_signed & bus.iB[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.iA + WIDTH'(1)) : bus.iA;
  assign w_b_mag = w_b_neg ? (~bus.iB + WIDTH'(1)) : bus.iB;

  assign w_sum  = bus.iA + bus.iB;
  assign w_diff = bus.iA - bus.iB;

  // Single-cycle ALU result and write legality
  always_comb begin
    w_alu   = '0;
    w_legal = 1'b1;
    case (bus.iALUCtrl)
      OP_AND:            w_alu = bus.iA & bus.iB;
      OP_OR:             w_alu = bus.iA | bus.iB;
      OP_ADD, OP_ADDU:   w_alu = w_sum;
      OP_SUB:            w_alu = w_diff;
      OP_SLT:            w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.iA) < $signed(bus.iB))};
      OP_NOR:            w_alu = ~(bus.iA | bus.iB);
      OP_MFHI:           w_alu = r_hi;
      OP_MFLO:           w_alu = r_lo;
      OP_MULT, OP_MULTU,
      OP_DIV, OP_DIVU:   w_alu = '0;
      default:           w_legal = 1'b0;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  assign w_ovf = ((bus.iALUCtrl == OP_ADD) && (bus.iA[WIDTH-1] == bus.iB[WIDTH-1]) &&
                  (w_sum[WIDTH-1] != bus.iA[WIDTH-1])) ||
                 ((bus.iALUCtrl == OP_SUB) && (bus.iA[WIDTH-1] != bus.iB[WIDTH-1]) &&
                  (w_diff[WIDTH-1] != bus.iA[WIDTH-1]));
`else
  assign w_ovf = 1'b0;
`endif

  // One iteration: restoring shift-subtract for divide, shift-add for multiply
  assign w_shift  = r_p[2*WIDTH-1:WIDTH-1];
  assign w_trial  = w_shift - {1'b0, r_m};
  assign w_addsum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
  assign w_step   = r_is_div ?
                    (w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0}
                                    : {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1})
                    : {w_addsum, r_p[WIDTH-1:1]};

  assign w_prod_neg = ~r_p + (2*WIDTH)'(1);
  assign w_quo      = r_p[WIDTH-1:0];
  assign w_rem      = r_p[2*WIDTH-1:WIDTH];

  // State, HI/LO and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_p      <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_rd     <= '0;
      r_rw     <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_md) begin
            r_state  <= S_BUSY;
            r_cnt    <= '0;
            r_is_div <= bus.iALUCtrl[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (bus.iB == '0);
            r_m      <= bus.iALUCtrl[1] ? w_b_mag : w_a_mag;
            r_p      <= {{WIDTH{1'b0}}, (bus.iALUCtrl[1] ? w_a_mag : w_b_mag)};
          end
        end
        S_BUSY: begin
          r_p <= w_step;
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_cnt   <= '0;
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_div0 ? '1 : (r_neg_q ? (~w_quo + WIDTH'(1)) : w_quo);
            r_hi <= r_neg_r ? (~w_rem + WIDTH'(1)) : w_rem;
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_p;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        r_valid  <= 1'b1;
        r_rd     <= bus.iRegDest;
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
        r_ovf    <= w_ovf;
        r_rw     <= bus.iRegWrite & w_legal & ~w_is_md & ~w_ovf;
      end else begin
        r_valid <= 1'b0;
        r_rw    <= 1'b0;
        r_ovf   <= 1'b0;
      end
    end
  end

  assign bus.oResult   = r_result;
  assign bus.oZero     = r_zero;
  assign bus.oRegDest  = r_rd;
  assign bus.oRegWrite = r_rw;
  assign bus.oValid    = r_valid;
  assign bus.oOverflow = r_ovf;
  assign bus.oStall    = w_stall;
  assign bus.oBusy     = w_busy;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage with an arithmetic reference model
// and a per-cycle compare process, plus literal expectations on key results.
module tb_ex_stage;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ex_stage_if bus ();
  ex_stage dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b,
                                            input logic [31:0] hi, lo);
    int ia, ib;
    ia = a; ib = b;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2, 4'd3: return a + b;
      4'd6:  return a - b;
      4'd7:  return (ia < ib) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      4'd13: return hi;
      4'd14: return lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic legal_model(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd13, 4'd14};
  endfunction

  function automatic logic ovf_model(input logic [3:0] op, input logic [31:0] a, b);
`ifdef EX_OVF_TRAP_EN
    int ia, ib;
    longint s;
    ia = a; ib = b;
    if (op == 4'd2) s = longint'(ia) + longint'(ib);
    else if (op == 4'd6) s = longint'(ia) - longint'(ib);
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
`else
    return 1'b0;
`endif
  endfunction

  // Returns {HI, LO}
  function automatic logic [63:0] md_model(input logic [3:0] op, input logic [31:0] a, b);
    int ia, ib;
    longint sa, sb;
    logic [63:0] p;
    ia = a; ib = b;
    case (op)
      4'd8: begin sa = ia; sb = ib; p = 64'(sa * sb); return p; end
      4'd9: begin p = {32'h0, a} * {32'h0, b}; return p; end
      4'd10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      4'd11: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  int          m_left;          // edges until HI/LO update; nonzero = unit busy
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic [31:0] e_result;
  logic [4:0]  e_rd;
  logic        e_zero, e_rw, e_valid, e_ovf;
  logic        m_busy, m_stall, m_dep;

  assign m_busy  = (m_left != 0);
  assign m_dep   = bus.iALUCtrl inside {4'd8, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14};
  assign m_stall = bus.iValid && m_busy && m_dep;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0; m_pend <= '0; m_hi <= '0; m_lo <= '0;
      e_result <= '0; e_rd <= '0; e_zero <= 1'b0; e_rw <= 1'b0; e_valid <= 1'b0; e_ovf <= 1'b0;
    end else begin
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
        end
      end
      if (bus.iValid && !m_stall) begin
        e_valid <= 1'b1;
        e_rd    <= bus.iRegDest;
        if (bus.iALUCtrl[3:2] == 2'b10) begin
          e_result <= '0; e_zero <= 1'b1; e_rw <= 1'b0; e_ovf <= 1'b0;
          m_pend   <= md_model(bus.iALUCtrl, bus.iA, bus.iB);
          m_left   <= 33;
        end else begin
          e_result <= alu_model(bus.iALUCtrl, bus.iA, bus.iB, m_hi, m_lo);
          e_zero   <= (alu_model(bus.iALUCtrl, bus.iA, bus.iB, m_hi, m_lo) == 32'h0);
          e_ovf    <= ovf_model(bus.iALUCtrl, bus.iA, bus.iB);
          e_rw     <= bus.iRegWrite && legal_model(bus.iALUCtrl) &&
                      !ovf_model(bus.iALUCtrl, bus.iA, bus.iB);
        end
      end else begin
        e_valid <= 1'b0; e_rw <= 1'b0; e_ovf <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    chk("valid",    32'(bus.oValid),    32'(e_valid));
    chk("regwrite", 32'(bus.oRegWrite), 32'(e_rw));
    chk("overflow", 32'(bus.oOverflow), 32'(e_ovf));
    chk("busy",     32'(bus.oBusy),     32'(m_busy));
    chk("stall",    32'(bus.oStall),    32'(m_stall));
    if (e_valid) begin
      chk("result", bus.oResult,        e_result);
      chk("zero",   32'(bus.oZero),     32'(e_zero));
      chk("regdest",32'(bus.oRegDest),  32'(e_rd));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [3:0] op, input logic [31:0] a, b, output int stalls);
    logic st, ok;
    ok = 1'b0;
    stalls = 0;
    bus.iValid = 1'b1; bus.iALUCtrl = op; bus.iA = a; bus.iB = b;
    bus.iRegDest = 5'($urandom_range(1, 31)); bus.iRegWrite = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clock);
      st = m_stall;
      @(posedge clock);
      #1;
      if (!st) begin ok = 1'b1; break; end
      stalls++;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    bus.iValid = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] exp);
    int s;
    send(op, a, b, s);
    chk(name, bus.oResult, exp);
  endtask

  task automatic rd_hilo(input string name, input logic [31:0] exp_hi, exp_lo);
    do_op({name, "_lo"}, 4'd14, 32'h0, 32'h0, exp_lo);
    do_op({name, "_hi"}, 4'd13, 32'h0, 32'h0, exp_hi);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bus.iValid = 1'b0; bus.iALUCtrl = '0; bus.iA = '0; bus.iB = '0;
    bus.iRegDest = '0; bus.iRegWrite = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      bus.iValid = 1'($urandom); bus.iALUCtrl = 4'($urandom); bus.iA = $urandom;
      bus.iB = $urandom; bus.iRegDest = 5'($urandom); bus.iRegWrite = 1'($urandom);
    end
    chk("rst_valid",  32'(bus.oValid), 32'd0);
    chk("rst_result", bus.oResult,     32'd0);
    chk("rst_busy",   32'(bus.oBusy),  32'd0);
    bus.iValid = 1'b0;
    reset_n = 1'b1;
    do_op("rst_mfhi", 4'd13, 32'h0, 32'h0, 32'h0);

    do_op("add_5_7", 4'd2, 32'd5, 32'd7, 32'd12);
    chk("add_zero", 32'(bus.oZero), 32'd0);
    chk("add_valid", 32'(bus.oValid), 32'd1);
    do_op("sub_7_7", 4'd6, 32'd7, 32'd7, 32'd0);
    chk("sub_zero", 32'(bus.oZero), 32'd1);
    do_op("slt_m1_1", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1);
    do_op("and", 4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234);
    do_op("nor", 4'd12, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF);
    do_op("unused", 4'd4, 32'd9, 32'd9, 32'd0);
    chk("unused_rw", 32'(bus.oRegWrite), 32'd0);

    // MULT with an immediately dependent MFLO
    send(4'd8, 32'hFFFF_FFFD, 32'd7, s);
    chk("mult_rw", 32'(bus.oRegWrite), 32'd0);
    send(4'd14, 32'h0, 32'h0, s);
    chk("mflo_stall_cycles", 32'(s), 32'd33);
    chk("mult_lo", bus.oResult, 32'hFFFF_FFEB);
    do_op("mult_hi", 4'd13, 32'h0, 32'h0, 32'hFFFF_FFFF);

    // ALU op runs alongside a busy unit
    send(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
    send(4'd2, 32'd100, 32'd23, s);
    chk("add_busy_stalls", 32'(s), 32'd0);
    chk("add_busy_result", bus.oResult, 32'd123);
    rd_hilo("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

    send(4'd11, 32'd100, 32'd7, s);
    rd_hilo("divu_100_7", 32'd2, 32'd14);
    send(4'd10, 32'hFFFF_FFF9, 32'd2, s);
    rd_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    send(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, s);
    rd_hilo("div_min_m1", 32'h0, 32'h8000_0000);
    send(4'd11, 32'h1234, 32'h0, s);
    rd_hilo("divu_by0", 32'h1234, 32'hFFFF_FFFF);
    send(4'd10, 32'hFFFF_FF00, 32'h0, s);
    rd_hilo("div_by0", 32'hFFFF_FF00, 32'hFFFF_FFFF);

    // Reset in the middle of a multiply
    send(4'd9, 32'h0001_FFFF, 32'h0003_0003, s);
    repeat (10) @(posedge clock);
    #3;
    bus.iValid = 1'b1; bus.iALUCtrl = 4'd13;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy",  32'(bus.oBusy),  32'd0);
    chk("midrst_stall", 32'(bus.oStall), 32'd0);
    chk("midrst_valid", 32'(bus.oValid), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    bus.iValid = 1'b0;
    rd_hilo("midrst_hilo", 32'h0, 32'h0);
    send(4'd9, 32'd3, 32'd4, s);
    rd_hilo("multu_3_4", 32'h0, 32'd12);

    // Signed overflow behaviour
    do_op("add_ovf_res", 4'd2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
`ifdef EX_OVF_TRAP_EN
    chk("add_ovf_flag", 32'(bus.oOverflow), 32'd1);
    chk("add_ovf_rw",   32'(bus.oRegWrite), 32'd0);
`else
    chk("add_ovf_flag", 32'(bus.oOverflow), 32'd0);
    chk("add_ovf_rw",   32'(bus.oRegWrite), 32'd1);
`endif
    do_op("addu_ovf_res", 4'd3, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    chk("addu_ovf_flag", 32'(bus.oOverflow), 32'd0);
    chk("addu_ovf_rw",   32'(bus.oRegWrite), 32'd1);

    repeat (2) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
